switch_debounce_edge: RTL and testbench



---
 rtl/switch_debounce_edge.sv | 111 +++++++++++
 tb/tb_switch_debounce_edge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_edge.sv
// Multi-channel push-button conditioner: two-flop synchronizer, per-channel
// debounce FSM, registered debounced level plus one-cycle rise/fall strobes.
module switch_debounce_edge #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_W          = $clog2(DEBOUNCE_LIMIT + 1)
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Switch,
  output logic [NUM_SWITCHES-1:0] o_Rise,
  output logic [NUM_SWITCHES-1:0] o_Fall
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [NUM_SWITCHES-1:0] sync1;
  logic [NUM_SWITCHES-1:0] sync2;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
    end
  end

  for (genvar n = 0; n < NUM_SWITCHES; n++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // The level register is updated on the same edge as the state change into
    // S_HIGH/S_LOW, so the strobe lines up with the first cycle of the new level.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          S_LOW: begin
            if (sync2[n]) begin
              state_q <= S_RISE_CHK;
              cnt_q   <= ONE;
            end
          end
          S_RISE_CHK: begin
            if (!sync2[n]) begin
              state_q <= S_LOW;
              cnt_q   <= '0;
            end else if (cnt_q == LIMIT) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          S_HIGH: begin
            if (!sync2[n]) begin
              state_q <= S_FALL_CHK;
              cnt_q   <= ONE;
            end
          end
          S_FALL_CHK: begin
            if (sync2[n]) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == LIMIT) begin
              state_q <= S_LOW;
              cnt_q   <= '0;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          default: begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign o_Switch[n] = level_q;
    assign o_Rise[n]   = rise_q;
    assign o_Fall[n]   = fall_q;
  end

endmodule

// File: tb/tb_switch_debounce_edge.sv
// Bench for switch_debounce_edge (4 channels, limit 8): vector table, corner
// sequences and random pin activity against a run-length reference model.
module tb_switch_debounce_edge;

  localparam int N = 4;
  localparam int L = 8;

  logic         i_Clk;
  logic         i_Rst_L;
  logic [N-1:0] i_Switch;
  logic [N-1:0] o_Switch;
  logic [N-1:0] o_Rise;
  logic [N-1:0] o_Fall;

  switch_debounce_edge #(
    .NUM_SWITCHES  (N),
    .DEBOUNCE_LIMIT(L)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Rise  (o_Rise),
    .o_Fall  (o_Fall)
  );

  // clock / reset
  logic clk_run = 1'b0;
  initial begin
    i_Clk = 1'b0;
    wait (clk_run);
    forever #5 i_Clk = ~i_Clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the FSM sees each pin value two edges after it is
  // applied; the level flips once L+1 consecutive seen samples differ from it.
  logic [N-1:0] dq[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;
  int           m_run[N];
  int           tot_rise;
  int           tot_fall;

  task automatic model_reset();
    dq = {};
    dq.push_back('0);
    dq.push_back('0);
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock edge, advance the model, compare #1 after the edge
  task automatic step();
    logic [N-1:0] smp;
    @(posedge i_Clk);
    smp = dq.pop_front();
    dq.push_back(i_Switch);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) begin
      if (smp[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == L + 1) begin
          m_run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) m_rise[c] = 1'b1;
          else          m_fall[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    #1;
    check("model", 32'({o_Switch, o_Rise, o_Fall}), 32'({m_lvl, m_rise, m_fall}));
    tot_rise += $countones(o_Rise);
    tot_fall += $countones(o_Fall);
  endtask

  typedef struct {
    logic [N-1:0] sw;
    int           hold;
    logic [N-1:0] exp_sw;
    int           exp_rise;
    int           exp_fall;
  } vec_t;

  vec_t tbl[$];

  int           hold_left[N];
  logic [N-1:0] pin;

  initial begin
    // release everything, then clean press/release on ch0
    tbl.push_back('{4'h0, 20, 4'h0, 0, 4});
    tbl.push_back('{4'h1, 20, 4'h1, 1, 0});
    tbl.push_back('{4'h0, 20, 4'h0, 0, 1});
    // ch2 near-miss: 8 high samples rejected, 9 accepted
    tbl.push_back('{4'h4,  8, 4'h0, 0, 0});
    tbl.push_back('{4'h0, 12, 4'h0, 0, 0});
    tbl.push_back('{4'h4,  9, 4'h0, 0, 0});
    tbl.push_back('{4'h0,  2, 4'h4, 1, 0});
    tbl.push_back('{4'h0, 12, 4'h0, 0, 1});
    // ch1 bounce every 3 cycles for 30 cycles, then a firm press
    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{4'h2, 3, 4'h0, 0, 0});
      tbl.push_back('{4'h0, 3, 4'h0, 0, 0});
    end
    tbl.push_back('{4'h2, 20, 4'h2, 1, 0});
    tbl.push_back('{4'h3, 20, 4'h3, 1, 0});

    // power-up reset with pins pressed and no clock
    i_Switch = 4'hF;
    i_Rst_L  = 1'b1;
    tot_rise = 0;
    tot_fall = 0;
    #1 i_Rst_L = 1'b0;
    #2 check("rst_idle", 32'({o_Switch, o_Rise, o_Fall}), 32'h0);
    #20 check("rst_hold", 32'({o_Switch, o_Rise, o_Fall}), 32'h0);
    model_reset();
    #5 i_Rst_L = 1'b1;
    #5 clk_run = 1'b1;
    repeat (10) step();
    step();
    check("pwr_rise", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'hF, 4'hF, 4'h0}));
    step();
    check("pwr_rise_end", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'hF, 4'h0, 4'h0}));

    // table-driven vectors
    foreach (tbl[i]) begin
      i_Switch = tbl[i].sw;
      tot_rise = 0;
      tot_fall = 0;
      repeat (tbl[i].hold) step();
      check($sformatf("tbl%0d_sw", i), 32'(o_Switch), 32'(tbl[i].exp_sw));
      check($sformatf("tbl%0d_rise", i), tot_rise, tbl[i].exp_rise);
      check($sformatf("tbl%0d_fall", i), tot_fall, tbl[i].exp_fall);
    end

    // ch0 release and ch3 press on the same edge
    i_Switch = 4'hA;
    repeat (10) step();
    check("sim_wait", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'h3, 4'h0, 4'h0}));
    step();
    check("sim_edge", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'hA, 4'h8, 4'h1}));
    step();
    check("sim_after", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'hA, 4'h0, 4'h0}));

    // reset while ch2 is mid rise-check (count 5)
    i_Switch = 4'hE;
    repeat (7) step();
    #1 i_Rst_L = 1'b0;
    #1 check("mid_rst", 32'({o_Switch, o_Rise, o_Fall}), 32'h0);
    model_reset();
    #1 i_Rst_L = 1'b1;
    repeat (10) step();
    step();
    check("mid_rst_rise", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'hE, 4'hE, 4'h0}));
    step();
    check("mid_rst_after", 32'({o_Switch, o_Rise, o_Fall}), 32'({4'hE, 4'h0, 4'h0}));

    // random pin activity, mixing bounces with long holds
    pin = i_Switch;
    for (int c = 0; c < N; c++) hold_left[c] = 0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          pin[c] = 1'($urandom_range(0, 1));
          hold_left[c] = int'($urandom_range(1, 14));
        end
        hold_left[c]--;
      end
      i_Switch = pin;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
